// File: rtl/spectrum_peak_fsm.sv
// Scans a bin window of the FFT output RAM, stores the L1 magnitude of each bin and reports the strongest bin.
// Latency: start to done = bins + last-return latency + 2 cycles; result port reads take 1 cycle.
// Backpressure: none; returns are accepted whenever fft_read_valid is high, and start is ignored while a scan runs.
module spectrum_peak_fsm #(
   parameter int ADDR_W  = 9,
   parameter int HALF_W  = 18,
   parameter int MIN_BIN = 1,
   parameter int MAX_BIN = 255
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   output logic [ADDR_W-1:0]     fft_address,
   output logic                  fft_read_enable,
   input  logic                  fft_read_valid,
   input  logic [2*HALF_W-1:0]   fft_data,
   input  logic [HALF_W:0]       threshold,
   output logic                  busy,
   output logic                  done,
   output logic                  peak_found,
   output logic [ADDR_W-1:0]     peak_bin,
   output logic [HALF_W:0]       peak_mag,
   input  logic [ADDR_W-1:0]     result_address,
   input  logic                  result_read_enable,
   output logic [HALF_W:0]       result_data,
   output logic                  result_read_valid
);

   localparam logic [ADDR_W:0]   NUM_BINS  = (ADDR_W+1)'(MAX_BIN - MIN_BIN + 1);
   localparam logic [ADDR_W-1:0] FIRST_BIN = ADDR_W'(MIN_BIN);
   localparam logic [ADDR_W-1:0] LAST_BIN  = ADDR_W'(MAX_BIN);
   localparam int                DEPTH     = 1 << ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_DRAIN  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     ret_cnt_q, ret_cnt_d;
   logic [HALF_W:0]     run_mag_q, run_mag_d;
   logic [ADDR_W-1:0]   run_bin_q, run_bin_d;
   logic [HALF_W:0]     peak_mag_q, peak_mag_d;
   logic [ADDR_W-1:0]   peak_bin_q, peak_bin_d;
   logic                peak_found_q, peak_found_d;
   logic [HALF_W:0]     rd_dat_q, rd_dat_d;
   logic                rd_vld_q, rd_vld_d;

   logic [HALF_W:0]     mag_mem [0:DEPTH-1];

   logic [HALF_W-1:0]   re_raw, im_raw;
   logic [HALF_W-1:0]   re_abs, im_abs;
   logic [HALF_W:0]     mag;
   logic [ADDR_W-1:0]   wr_addr;
   logic                wr_en;
   logic                ret_accept;

   // Two's-complement negate in HALF_W bits is exact as unsigned, so the most negative value becomes 2**(HALF_W-1).
   always_comb begin
      re_raw = fft_data[2*HALF_W-1:HALF_W];
      im_raw = fft_data[HALF_W-1:0];
      re_abs = re_raw[HALF_W-1] ? (~re_raw + 1'b1) : re_raw;
      im_abs = im_raw[HALF_W-1] ? (~im_raw + 1'b1) : im_raw;
      mag    = {1'b0, re_abs} + {1'b0, im_abs};
   end

   assign wr_addr    = FIRST_BIN + ret_cnt_q[ADDR_W-1:0];
   assign ret_accept = fft_read_valid && (state_q == S_ISSUE || state_q == S_DRAIN)
                       && (ret_cnt_q != NUM_BINS);

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      ret_cnt_d    = ret_cnt_q;
      run_mag_d    = run_mag_q;
      run_bin_d    = run_bin_q;
      peak_mag_d   = peak_mag_q;
      peak_bin_d   = peak_bin_q;
      peak_found_d = peak_found_q;
      wr_en        = 1'b0;

      // Strictly-greater keeps the lowest bin on ties.
      if (ret_accept) begin
         wr_en     = 1'b1;
         ret_cnt_d = ret_cnt_q + 1'b1;
         if (mag > run_mag_q) begin
            run_mag_d = mag;
            run_bin_d = wr_addr;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               run_mag_d = '0;
               run_bin_d = FIRST_BIN;
               addr_d    = FIRST_BIN;
               ret_cnt_d = '0;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (addr_q == LAST_BIN) begin
               state_d = S_DRAIN;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (ret_cnt_q == NUM_BINS) begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            peak_bin_d   = run_bin_q;
            peak_mag_d   = run_mag_q;
            peak_found_d = (run_mag_q >= threshold);
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         ret_cnt_q    <= '0;
         run_mag_q    <= '0;
         run_bin_q    <= '0;
         peak_mag_q   <= '0;
         peak_bin_q   <= '0;
         peak_found_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         ret_cnt_q    <= ret_cnt_d;
         run_mag_q    <= run_mag_d;
         run_bin_q    <= run_bin_d;
         peak_mag_q   <= peak_mag_d;
         peak_bin_q   <= peak_bin_d;
         peak_found_q <= peak_found_d;
      end
   end

   // Buffer contents survive reset; only the write strobe is gated.
   always_ff @(posedge clk) begin
      if (wr_en && reset_n) begin
         mag_mem[wr_addr] <= mag;
      end
   end

   // Registered read data gives read-before-write on a same-cycle collision.
   always_comb begin
      rd_vld_d = result_read_enable;
      rd_dat_d = result_read_enable ? mag_mem[result_address] : rd_dat_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_vld_q <= 1'b0;
         rd_dat_q <= '0;
      end else begin
         rd_vld_q <= rd_vld_d;
         rd_dat_q <= rd_dat_d;
      end
   end

   assign busy              = (state_q == S_ISSUE) || (state_q == S_DRAIN);
   assign done              = (state_q == S_FINISH);
   assign fft_read_enable   = (state_q == S_ISSUE);
   assign fft_address       = (state_q == S_ISSUE) ? addr_q : '0;
   assign peak_found        = peak_found_q;
   assign peak_bin          = peak_bin_q;
   assign peak_mag          = peak_mag_q;
   assign result_read_valid = rd_vld_q;
   assign result_data       = rd_vld_q ? rd_dat_q : '0;

endmodule
